// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RISC-V core.
//
// Owns the word-addressed PC and drives it to the instruction memory's
// combinational read port. The returned word is captured into an IF/ID
// register, which is handed to decode through a valid/ready handshake.
// Supports stall (decoder back-pressure), redirect (branch/jump flush) and
// halt.
//
// Optional feature macro: FETCH_NOP_SQUASH_EN
//   When defined, all-zero instruction words are dropped at fetch. The PC
//   still advances, but decode never sees the word.
//
// Parameters:
//   PC_W      word-address width (1024-word instruction memory)
//   INSTR_W   instruction width
//   RESET_PC  PC loaded on reset
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   pc_o              word address to instruction memory (= PC register)
//   instr_i           combinational read data for pc_o
//   redirect_valid_i  taken branch/jump; load redirect_pc_i
//   redirect_pc_i     redirect target (word address)
//   halt_i            stop fetching
//   dec_ready_i       decoder accepts IF/ID this cycle
//   if_valid_o        IF/ID holds a live instruction
//   if_instr_o        captured instruction
//   if_pc_o           address of if_instr_o
//   halted_o          FSM is in HALT
module fetch_stage #(
    parameter int          PC_W     = 10,
    parameter int          INSTR_W  = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               redirect_valid_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    input  logic               halt_i,
    input  logic               dec_ready_i,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [PC_W-1:0]    if_pc_o,
    output logic               halted_o
);

    typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               vld_q, vld_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ifpc_q, ifpc_d;

    logic free;    // IF/ID can take a new word on this edge
    logic redir;   // redirect honoured (ignored during BOOT)
    logic active;  // states that are allowed to capture

    assign free   = !vld_q || dec_ready_i;
    assign redir  = redirect_valid_i && (state_q != BOOT);
    assign active = (state_q == RUN) || (state_q == STALL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic; priority redirect > halt > stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, STALL: begin
                if (redir)                      state_d = RUN;
                else if (halt_i)                state_d = HALT;
                else if (vld_q && !dec_ready_i) state_d = STALL;
                else                            state_d = RUN;
            end
            HALT: if (redir) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        pc_d    = pc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        if (redir) begin
            // Flush the wrong-path word; the target is fetched next cycle
            pc_d  = redirect_pc_i;
            vld_d = 1'b0;
        end else if (active && !halt_i && free) begin
            pc_d = pc_q + PC_W'(1);   // silent wrap at 2^PC_W
`ifdef FETCH_NOP_SQUASH_EN
            if (instr_i == '0) begin
                vld_d = 1'b0;
            end else begin
                vld_d   = 1'b1;
                instr_d = instr_i;
                ifpc_d  = pc_q;
            end
`else
            vld_d   = 1'b1;
            instr_d = instr_i;
            ifpc_d  = pc_q;
`endif
        end else if (vld_q && dec_ready_i) begin
            // Transfer with no refill (halting or halted): drain the register
            vld_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_W'(RESET_PC);
            vld_q   <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    assign pc_o       = pc_q;
    assign if_valid_o = vld_q;
    assign if_instr_o = instr_q;
    assign if_pc_o    = ifpc_q;
    assign halted_o   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pc_o;
    logic [31:0] instr_i;
    logic        redirect_valid_i = 1'b0;
    logic [9:0]  redirect_pc_i = '0;
    logic        halt_i = 1'b0;
    logic        dec_ready_i = 1'b1;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [9:0]  if_pc_o;
    logic        halted_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(10), .INSTR_W(32), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .instr_i(instr_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .halt_i(halt_i), .dec_ready_i(dec_ready_i),
        .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
        .halted_o(halted_o)
    );

    // Instruction memory model: words 0..2 from the plan, word 3 a nop (0),
    // everything else a distinct addi encoding carrying its own address.
    function automatic logic [31:0] mword(input logic [9:0] a);
        case (a)
            10'd0:   return 32'h00100513;
            10'd1:   return 32'h00150593;
            10'd2:   return 32'h00250613;
            10'd3:   return 32'h00000000;
            default: return {2'b00, a, 20'h00013};
        endcase
    endfunction

    assign instr_i = mword(pc_o);

    typedef struct {
        logic       rdv;
        logic [9:0] rdpc;
        logic       halt;
        logic       rdy;
        logic       vld;
        logic [9:0] ifpc;
        logic [9:0] pco;
        logic       hlt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdv, input logic [9:0] rdpc, input logic halt,
                       input logic rdy, input logic vld, input logic [9:0] ifpc,
                       input logic [9:0] pco, input logic hlt);
        vec_t v;
        v.rdv = rdv; v.rdpc = rdpc; v.halt = halt; v.rdy = rdy;
        v.vld = vld; v.ifpc = ifpc; v.pco = pco; v.hlt = hlt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdv, input logic [9:0] rdpc, input logic halt, input logic rdy);
        redirect_valid_i = rdv;
        redirect_pc_i    = rdpc;
        halt_i           = halt;
        dec_ready_i      = rdy;
    endtask

    initial begin
        // Edge-by-edge script after reset release: inputs before the edge,
        // expected outputs after it.          rdv rdpc halt rdy | vld ifpc pc_o hlt
        add(0, 0,    0, 1,  0, 0,    0,    0);  // E1  BOOT, no capture
        add(0, 0,    0, 1,  1, 0,    1,    0);  // E2
        add(0, 0,    0, 1,  1, 1,    2,    0);  // E3
        add(0, 0,    0, 0,  1, 1,    2,    0);  // E4  stall
        add(0, 0,    0, 0,  1, 1,    2,    0);  // E5
        add(0, 0,    0, 0,  1, 1,    2,    0);  // E6
        add(0, 0,    0, 1,  1, 2,    3,    0);  // E7  ready returns
`ifdef FETCH_NOP_SQUASH_EN
        add(0, 0,    0, 1,  0, 0,    4,    0);  // E8  nop squashed
`else
        add(0, 0,    0, 1,  1, 3,    4,    0);  // E8  nop passed through
`endif
        add(0, 0,    0, 1,  1, 4,    5,    0);  // E9
        add(0, 0,    0, 1,  1, 5,    6,    0);  // E10
        add(0, 0,    1, 0,  1, 5,    6,    1);  // E11 halt, word pending
        add(0, 0,    1, 0,  1, 5,    6,    1);  // E12
        add(0, 0,    1, 1,  0, 0,    6,    1);  // E13 drained by transfer
        add(0, 0,    0, 1,  0, 0,    6,    1);  // E14 stays halted
        add(1, 0,    0, 1,  0, 0,    0,    0);  // E15 redirect leaves HALT
        add(0, 0,    0, 1,  1, 0,    1,    0);  // E16
        add(0, 0,    0, 1,  1, 1,    2,    0);  // E17
        add(0, 0,    0, 1,  1, 2,    3,    0);  // E18
`ifdef FETCH_NOP_SQUASH_EN
        add(0, 0,    0, 1,  0, 0,    4,    0);  // E19
`else
        add(0, 0,    0, 1,  1, 3,    4,    0);  // E19
`endif
        add(0, 0,    0, 1,  1, 4,    5,    0);  // E20
        add(0, 0,    0, 0,  1, 4,    5,    0);  // E21 stall at if_pc 4
        add(1, 20,   0, 0,  0, 0,    20,   0);  // E22 redirect wins over stall
        add(0, 0,    0, 1,  1, 20,   21,   0);  // E23
        add(1, 1023, 1, 1,  0, 0,    1023, 0);  // E24 redirect wins over halt
        add(0, 0,    0, 1,  1, 1023, 0,    0);  // E25 wrap
        add(0, 0,    0, 1,  1, 0,    1,    0);  // E26

        // Reset state
        #2;
        chk("rst_pc_o",   32'(pc_o), 32'd0);
        chk("rst_valid",  32'(if_valid_o), 32'd0);
        chk("rst_if_pc",  32'(if_pc_o), 32'd0);
        chk("rst_instr",  if_instr_o, 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rdv, vecs[i].rdpc, vecs[i].halt, vecs[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("row%0d_valid", i),  32'(if_valid_o), 32'(vecs[i].vld));
            chk($sformatf("row%0d_pc_o", i),   32'(pc_o), 32'(vecs[i].pco));
            chk($sformatf("row%0d_halted", i), 32'(halted_o), 32'(vecs[i].hlt));
            if (vecs[i].vld) begin
                chk($sformatf("row%0d_if_pc", i), 32'(if_pc_o), 32'(vecs[i].ifpc));
                chk($sformatf("row%0d_instr", i), if_instr_o, mword(vecs[i].ifpc));
            end
        end

        // Reset mid-stall: pending word dropped asynchronously
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
        chk("stall_pre_valid", 32'(if_valid_o), 32'd1);
        chk("stall_pre_if_pc", 32'(if_pc_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(if_valid_o), 32'd0);
        chk("async_rst_pc_o",  32'(pc_o), 32'd0);
        chk("async_rst_if_pc", 32'(if_pc_o), 32'd0);

        // Redirect during BOOT is ignored
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 100, 0, 1);
        @(posedge clk); #1;
        chk("boot_redir_pc_o",  32'(pc_o), 32'd0);
        chk("boot_redir_valid", 32'(if_valid_o), 32'd0);
        drive(0, 0, 0, 1);
        @(posedge clk); #1;
        chk("boot_first_valid", 32'(if_valid_o), 32'd1);
        chk("boot_first_if_pc", 32'(if_pc_o), 32'd0);
        chk("boot_first_instr", if_instr_o, 32'h00100513);
        chk("boot_first_pc_o",  32'(pc_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the single-cycle/pipelined RISC-V core. It sits directly upstream of the instruction memory. It owns the program counter, drives the word address to the memory's combinational read port, and captures the returned word into an IF/ID register. That register is presented to the decoder through a valid/ready handshake, with support for stall, redirect (branch/jump flush) and halt.

## Interface
- `PC_W`, 10: word-address width; matches the instruction memory depth of 1024 words.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `pc_o` out PC_W: word address to the instruction memory; equal to the PC register.
- `instr_i` in INSTR_W: combinational read data for `pc_o`; valid in the same cycle.
- `redirect_valid_i` in 1: branch/jump taken; load `redirect_pc_i`.
- `redirect_pc_i` in PC_W: redirect target, as a word address.
- `halt_i` in 1: stop fetching; ebreak or end of program.
- `dec_ready_i` in 1: decoder accepts the IF/ID contents this cycle.
- `if_valid_o` out 1: IF/ID holds a live instruction.
- `if_instr_o` out INSTR_W: captured instruction.
- `if_pc_o` out PC_W: address of `if_instr_o`.
- `halted_o` out 1: FSM is in HALT.

## Operation
- A transfer to decode occurs on a clock edge where `if_valid_o && dec_ready_i`.
- The IF/ID register is "free" when `!if_valid_o || dec_ready_i`.
- FSM states: BOOT, RUN, STALL, HALT.
  - BOOT: entered on reset. Lasts exactly one cycle with no capture, then goes to RUN.
  - RUN, register free:
    - capture `instr_i` into `if_instr_o` and `pc_o` into `if_pc_o`;
    - set `if_valid_o` to 1;
    - set PC to PC+1.
  - RUN → STALL: when `if_valid_o && !dec_ready_i`. No capture; PC is held.
  - STALL: IF/ID and PC are held stable. Returns to RUN on the edge where `dec_ready_i` is high; that edge also performs the RUN capture.
  - RUN/STALL → HALT: `halt_i` sampled high. PC is frozen. A pending IF/ID word is kept until transferred, then `if_valid_o` goes to 0. No new captures.
  - HALT exit: only by redirect (→ RUN) or reset.
- Redirect, from any state except BOOT:
  - PC is set to `redirect_pc_i`;
  - `if_valid_o` is set to 0 (the wrong-path word is flushed);
  - the FSM goes to RUN;
  - no capture on that edge.
- Priority: reset > redirect > halt > stall/capture.
- Arithmetic: PC+1 is modulo 2^PC_W. After 1023 the PC is 0; wrap is silent and raises no flag.

## Timing
- Reset values, applied asynchronously:
  - PC = `RESET_PC`, so `pc_o` = `RESET_PC`;
  - `if_valid_o` = 0;
  - `if_instr_o` = 0;
  - `if_pc_o` = 0;
  - `halted_o` = 0;
  - FSM = BOOT.
- Reset asserted mid-operation drops any pending IF/ID word immediately, without waiting for a clock edge.
- First valid output: the second rising edge after `rst_n` deasserts gives `if_pc_o` = `RESET_PC`.
- Latency: the word addressed by `pc_o` in cycle N appears on `if_instr_o` after edge N+1. Throughput is one instruction per cycle while `dec_ready_i` stays high.
- Redirect penalty: one bubble. The target appears on `if_pc_o` two edges after the redirect is sampled.
- A redirect and a stall in the same cycle: the redirect wins and the stalled word is discarded.
- A redirect and `halt_i` in the same cycle: the redirect wins; the FSM does not enter HALT.
- `halted_o` rises on the edge that enters HALT.
- All outputs are registered. The only combinational path is `pc_o` → `instr_i`, which is external.

## Configuration
- `FETCH_NOP_SQUASH_EN`:
  - Defined: an all-zero `instr_i` (the codebase's nop encoding) is not captured. `if_valid_o` is set to 0 for that cycle, the PC still advances, and decode never sees the word.
  - Undefined: all-zero words are captured and passed to decode like any other instruction.
- Squashing happens only when the register is free and no redirect or halt is active.

## Test plan
- Reset/boot:
  - Stimulus: memory words 0..2 = 0x00100513, 0x00150593, 0x00250613; `dec_ready_i` = 1; release `rst_n`.
  - Required: `if_valid_o` = 0 on edge 1. `if_pc_o`/`if_instr_o` = 0/0x00100513, 1/0x00150593, 2/0x00250613 on edges 2, 3, 4.
- Stall:
  - Stimulus: `dec_ready_i` = 0 for 3 cycles while `if_pc_o` = 1.
  - Required: `if_pc_o` = 1, `if_instr_o` = 0x00150593, `pc_o` = 2 all stable. One edge after ready returns, `if_pc_o` = 2.
- Redirect during stall:
  - Stimulus: `if_pc_o` = 4 stalled; `redirect_pc_i` = 20.
  - Required: next edge gives `if_valid_o` = 0 and `pc_o` = 20. The following edge gives `if_pc_o` = 20 and `pc_o` = 21.
- Wrap-around:
  - Stimulus: redirect to 1023.
  - Required: `if_pc_o` sequence 1023 then 0; `pc_o` = 1 afterwards.
- Nop squash:
  - Stimulus: word 3 = 0.
  - Required with the macro defined: `if_pc_o` sequence 2, (bubble), 4.
  - Required without the macro: sequence 2, 3, 4, with `if_instr_o` = 0 at address 3.
- Halt, and reset mid-stall:
  - Stimulus: assert `halt_i` at `pc_o` = 6, then redirect to 0.
  - Required: `halted_o` = 1; PC frozen at 6; `if_valid_o` goes to 0 after one transfer. The redirect to 0 resumes fetch.
  - Then, while `if_valid_o` = 1, drive `rst_n` low. Required: `if_valid_o` = 0 and `pc_o` = 0 before the next clock edge.
